// File: rtl/fifo_read_ctrl.sv
// Read side of the async FIFO: pops RAM words into a one-entry valid/ready output stage.
// Data appears one cycle after mem_ren; no pop is issued while the held word is stalled.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = PW'(AE_THRESH);

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rbin_next;
  logic [ADDR_WIDTH:0] wbin;

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    wbin       = gray2bin(wptr_gray_sync);
    // Modular difference keeps full (SIZE) distinct from empty via the extra MSB.
    fill_level = wbin - rbin;
    empty      = (rptr_gray == wptr_gray_sync);
    almost_empty = (fill_level <= AE_LEVEL);
    rbin_next  = rbin + 1'b1;
    mem_ren    = r_rst_n & ~empty & (~m_valid | m_ready);
    mem_raddr  = rbin[ADDR_WIDTH-1:0];
    m_data     = mem_rdata;
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      m_valid   <= 1'b0;
    end else begin
      if (mem_ren) begin
        rbin      <= rbin_next;
        rptr_gray <= bin2gray(rbin_next);
        m_valid   <= 1'b1;
      end else if (m_ready) begin
        m_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized bench for fifo_read_ctrl against a counter/queue model of the read side.
module tb_fifo_read_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic [4:0] wptr_gray_sync = '0;
  logic [7:0] mem_rdata = '0;
  logic       mem_ren;
  logic [3:0] mem_raddr;
  logic [4:0] rptr_gray;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       empty;
  logic       almost_empty;
  logic [4:0] fill_level;

  fifo_read_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AE_THRESH(2)) dut (
    .r_clk(r_clk), .r_rst_n(r_rst_n), .wptr_gray_sync(wptr_gray_sync),
    .mem_rdata(mem_rdata), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .rptr_gray(rptr_gray), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .empty(empty), .almost_empty(almost_empty), .fill_level(fill_level)
  );

  always #5 r_clk = ~r_clk;

  // Bench-side dual-port RAM: registered read, holds while mem_ren is low.
  logic [7:0] ram [16];
  always @(posedge r_clk) if (mem_ren) mem_rdata <= ram[mem_raddr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  // Reference model: total words written/popped, the output-stage flag and word.
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  bit         vm = 1'b0;
  logic [7:0] held = '0;
  bit         known = 1'b0;
  logic [7:0] q[$];
  logic [4:0] prev_gray = '0;
  bit         prev_ok = 1'b0;

  task automatic step(input bit rst, input int add, input bit rdy);
    int  fill;
    bit  pop;
    logic [7:0] d;
    @(negedge r_clk);
    for (int i = 0; i < add; i++) begin
      d = 8'($urandom);
      ram[wr_cnt % 16] = d;
      q.push_back(d);
      wr_cnt++;
    end
    wptr_gray_sync = gray5(wr_cnt);
    m_ready = rdy;
    r_rst_n = rst;
    #1;
    fill = (wr_cnt - rd_cnt) & 31;
    pop  = rst && known && (fill != 0) && (!vm || rdy);
    chk("mem_ren", 32'(mem_ren), 32'(pop));
    if (known) begin
      chk("fill_level", 32'(fill_level), 32'(fill));
      chk("empty", 32'(empty), 32'(fill == 0));
      chk("almost_empty", 32'(almost_empty), 32'(fill <= 2));
      chk("rptr_gray", 32'(rptr_gray), 32'(gray5(rd_cnt)));
      chk("m_valid", 32'(m_valid), 32'(vm));
      if (vm) chk("m_data", 32'(m_data), 32'(held));
      if (pop) chk("mem_raddr", 32'(mem_raddr), 32'(rd_cnt % 16));
      if (prev_ok && rptr_gray != prev_gray)
        chk("gray_step", 32'($countones(rptr_gray ^ prev_gray)), 32'd1);
      prev_gray = rptr_gray;
      prev_ok   = rst;
    end
    if (!rst) begin
      rd_cnt = 0;
      vm     = 1'b0;
      known  = 1'b1;
      prev_ok = 1'b0;
    end else if (pop) begin
      held = q.pop_front();
      rd_cnt++;
      vm = 1'b1;
    end else if (rdy) begin
      vm = 1'b0;
    end
  endtask

  // Write side restarts together with the read side after a reset.
  task automatic clear_write_side();
    q.delete();
    wr_cnt = 0;
  endtask

  initial begin
    int budget;
    int add;
    // Reset then idle
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1);

    // Streaming: three words, continuous pops
    step(1'b1, 3, 1'b1);
    repeat (5) step(1'b1, 0, 1'b1);
    chk("stream_empty", 32'(empty), 32'd1);
    chk("stream_rptr", 32'(rptr_gray), 32'b00010);

    // Backpressure: four words, single pop then stall
    step(1'b1, 4, 1'b0);
    repeat (4) step(1'b1, 0, 1'b0);
    chk("bp_fill", 32'(fill_level), 32'd3);
    repeat (6) step(1'b1, 0, 1'b1);

    // Full + wrap: bring rbin to 30, then fill to 16
    budget = 0;
    while ((wr_cnt < 30 || rd_cnt != wr_cnt) && budget < 200) begin
      step(1'b1, (wr_cnt < 30) ? 1 : 0, 1'b1);
      budget++;
    end
    chk("prefill_budget", 32'(budget < 200), 32'd1);
    step(1'b1, 16, 1'b0);
    chk("full_fill", 32'(fill_level), 32'd16);
    chk("full_empty", 32'(empty), 32'd0);
    repeat (20) step(1'b1, 0, 1'b1);
    chk("wrap_rptr_eq_wptr", 32'(rptr_gray), 32'(wptr_gray_sync));
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-stream with a held word and fill 5
    step(1'b1, 6, 1'b0);
    step(1'b1, 0, 1'b0);
    chk("mid_valid", 32'(m_valid), 32'd1);
    chk("mid_fill", 32'(fill_level), 32'd5);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rptr", 32'(rptr_gray), 32'd0);
    clear_write_side();

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 0, 1'($urandom));
        clear_write_side();
      end else begin
        add = $urandom_range(0, 2);
        if (wr_cnt - rd_cnt + add > 16) add = 16 - (wr_cnt - rd_cnt);
        step(1'b1, add, ($urandom_range(0, 3) != 0));
      end
    end
    repeat (25) step(1'b1, 0, 1'b1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
